conv_pass_scheduler: RTL and testbench

//  Sequences the 3x3 pre-convolution datapath (pad -> line buffer -> PE) over all
//  (output-channel, input-channel) pairs of one layer. It streams each input-channel

---
 rtl/conv_pass_scheduler_if.sv | 41 ++++
 rtl/conv_pass_scheduler.sv | 120 ++++++++++++
 tb/tb_conv_pass_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pass_scheduler_if.sv
// Handshake/bus bundle between the pass scheduler (master) and its controller/datapath (slave).
interface conv_pass_scheduler_if #(
  parameter int IMG_SIZE = 14,
  parameter int IN_CH    = 4,
  parameter int OUT_CH   = 8
);
  localparam int N  = IMG_SIZE * IMG_SIZE;
  localparam int AW = $clog2(IN_CH * N);
  localparam int BW = $clog2(OUT_CH * IN_CH);
  localparam int RW = $clog2(N);
  localparam int OW = $clog2(OUT_CH);

  logic          start;
  logic          busy;
  logic          done;
  logic          fmap_rd;
  logic [AW-1:0] fmap_addr;
  logic          pix_valid;
  logic          conv_ready;
  logic          conv_clr;
  logic          w_load;
  logic [BW-1:0] w_bank_sel;
  logic          conv_valid;
  logic [RW-1:0] res_idx;
  logic          psum_first;
  logic          psum_last;
  logic [OW-1:0] oc_idx;
  logic          ovf_err;

  modport master (
    input  start, conv_ready, conv_valid,
    output busy, done, fmap_rd, fmap_addr, pix_valid, conv_clr, w_load,
           w_bank_sel, res_idx, psum_first, psum_last, oc_idx, ovf_err
  );

  modport slave (
    output start, conv_ready, conv_valid,
    input  busy, done, fmap_rd, fmap_addr, pix_valid, conv_clr, w_load,
           w_bank_sel, res_idx, psum_first, psum_last, oc_idx, ovf_err
  );
endinterface

// File: rtl/conv_pass_scheduler.sv
// Walks every (output-channel, input-channel) pass of a 3x3 conv layer: clear, load weights,
// stream one feature map, count PE results and tag them for the partial-sum accumulator.
module conv_pass_scheduler #(
  parameter int IMG_SIZE = 14,
  parameter int IN_CH    = 4,
  parameter int OUT_CH   = 8
) (
  input  logic clk,
  input  logic reset,
  conv_pass_scheduler_if.master bus
);
  localparam int N   = IMG_SIZE * IMG_SIZE;
  localparam int AW  = $clog2(IN_CH * N);
  localparam int BW  = $clog2(OUT_CH * IN_CH);
  localparam int RW  = $clog2(N);
  localparam int OW  = $clog2(OUT_CH);
  localparam int CW  = $clog2(N + 1);
  localparam int ICW = $clog2(IN_CH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_NEXT   = 3'd5;
  localparam logic [2:0] S_FIN    = 3'd6;

  logic [2:0]     state;
  logic [CW-1:0]  rd_cnt;
  logic [CW-1:0]  res_cnt;
  logic [ICW-1:0] ic;
  logic [OW-1:0]  oc;
  logic           pix_valid_q;
  logic           ovf_q;
  logic           in_pass;
  logic           rd_fire;
  logic           res_fire;
  logic           last_pass;

  assign in_pass   = (state == S_STREAM) || (state == S_DRAIN);
  assign rd_fire   = (state == S_STREAM) && bus.conv_ready && (rd_cnt < CW'(N));
  assign res_fire  = in_pass && bus.conv_valid && (res_cnt < CW'(N));
  assign last_pass = (oc == OW'(OUT_CH - 1)) && (ic == ICW'(IN_CH - 1));

  // Results are only counted while a pass is live; anything else is an overflow and sticks.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rd_cnt      <= '0;
      res_cnt     <= '0;
      ic          <= '0;
      oc          <= '0;
      pix_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pix_valid_q <= rd_fire;
      if (bus.conv_valid && (!in_pass || (res_cnt == CW'(N))))
        ovf_q <= 1'b1;
      if (res_fire)
        res_cnt <= res_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ic    <= '0;
            oc    <= '0;
            state <= S_CLR;
          end
        end
        S_CLR: begin
          rd_cnt  <= '0;
          res_cnt <= '0;
          state   <= S_LOAD_W;
        end
        S_LOAD_W: state <= S_STREAM;
        S_STREAM: begin
          if (rd_fire) begin
            rd_cnt <= rd_cnt + CW'(1);
            if (rd_cnt == CW'(N - 1))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (res_cnt == CW'(N))
            state <= S_NEXT;
        end
        S_NEXT: begin
          // On the final pass oc is left alone and only wraps to 0 via FIN.
          if (ic == ICW'(IN_CH - 1)) begin
            ic <= '0;
            if (!last_pass)
              oc <= oc + OW'(1);
          end else begin
            ic <= ic + ICW'(1);
          end
          state <= last_pass ? S_FIN : S_CLR;
        end
        S_FIN: begin
          oc    <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = (state != S_IDLE) && (state != S_FIN);
  assign bus.done       = (state == S_FIN);
  assign bus.fmap_rd    = rd_fire;
  assign bus.fmap_addr  = AW'(ic) * AW'(N) + AW'(rd_cnt);
  assign bus.pix_valid  = pix_valid_q;
  assign bus.conv_clr   = (state == S_CLR);
  assign bus.w_load     = (state == S_LOAD_W);
  assign bus.w_bank_sel = BW'(oc) * BW'(IN_CH) + BW'(ic);
  assign bus.res_idx    = in_pass ? res_cnt[RW-1:0] : '0;
  assign bus.psum_first = in_pass && (ic == '0);
  assign bus.psum_last  = in_pass && (ic == ICW'(IN_CH - 1));
  assign bus.oc_idx     = oc;
  assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Drives whole layers through the pass scheduler with a 5-cycle datapath model and checks
// read addresses, weight banks, result tags, overflow flag and done timing against pass arithmetic.
module tb_conv_pass_scheduler;
  localparam int IMG_SIZE = 4;
  localparam int IN_CH    = 2;
  localparam int OUT_CH   = 2;
  localparam int N        = IMG_SIZE * IMG_SIZE;
  localparam int PASSES   = IN_CH * OUT_CH;
  localparam int P_LEN    = N + 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [5:0] pv_hist = '0;
  logic inject_now = 1'b0;

  always #5 clk = ~clk;

  conv_pass_scheduler_if #(.IMG_SIZE(IMG_SIZE), .IN_CH(IN_CH), .OUT_CH(OUT_CH)) bus ();

  conv_pass_scheduler #(.IMG_SIZE(IMG_SIZE), .IN_CH(IN_CH), .OUT_CH(OUT_CH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One cycle: the datapath model returns each pix_valid five cycles later on conv_valid.
  task automatic applyStimulus(input logic st, input logic rdy, input logic rst);
    @(negedge clk);
    pv_hist = {pv_hist[4:0], bus.pix_valid};
    bus.start      = st;
    bus.conv_ready = rdy;
    reset          = rst;
    bus.conv_valid = (rst ? 1'b0 : pv_hist[5]) | inject_now;
    if (rst) pv_hist = '0;
    #1;
    cyc++;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_fmap_rd"}, bus.fmap_rd, 0);
    checkOutput({tag, "_fmap_addr"}, bus.fmap_addr, 0);
    checkOutput({tag, "_pix_valid"}, bus.pix_valid, 0);
    checkOutput({tag, "_conv_clr"}, bus.conv_clr, 0);
    checkOutput({tag, "_w_load"}, bus.w_load, 0);
    checkOutput({tag, "_w_bank_sel"}, bus.w_bank_sel, 0);
    checkOutput({tag, "_res_idx"}, bus.res_idx, 0);
    checkOutput({tag, "_psum_first"}, bus.psum_first, 0);
    checkOutput({tag, "_psum_last"}, bus.psum_last, 0);
    checkOutput({tag, "_oc_idx"}, bus.oc_idx, 0);
    checkOutput({tag, "_ovf_err"}, bus.ovf_err, 0);
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic runLayer(input int mode, input bit inject, input bit stray, input int rst_pass,
                          input bit ovf_start);
    int  n = 0, pass = -1, reads = 0, results = 0, loads = 0, dones = 0;
    int  total_reads = 0, total_res = 0;
    bit  exp_ovf = ovf_start, pend_inject = 0, was_rd = 0, finished = 0, do_rst;
    logic rdy, st;

    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("busy_at_start", bus.busy, 0);
    while (!finished) begin
      n++;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((n % 3) == 1);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      st = stray && ((n % 37) == 5);
      inject_now = pend_inject;
      pend_inject = 0;
      do_rst = (pass == rst_pass) && (reads == 7);
      if (do_rst) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        inject_now = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdle("reset_mid_pass");
        return;
      end
      applyStimulus(st, rdy, 1'b0);

      if (n == 1) begin
        checkOutput("busy_after_start", bus.busy, 1);
        checkOutput("clr_after_start", bus.conv_clr, 1);
      end
      checkOutput("pix_valid_follows_rd", bus.pix_valid, was_rd);
      checkOutput("rd_without_ready", bus.fmap_rd && !rdy, 0);
      checkOutput("ovf_err", bus.ovf_err, exp_ovf);
      if (bus.conv_valid && inject_now) exp_ovf = 1;

      if (bus.w_load) begin
        if (loads > 0) begin
          checkOutput("reads_per_pass", reads, N);
          checkOutput("results_per_pass", results, N);
        end
        checkOutput("w_bank_sel_load", bus.w_bank_sel, loads);
        loads++;
        pass = loads - 1;
        reads = 0;
        results = 0;
      end
      if (bus.fmap_rd) begin
        checkOutput("fmap_addr", bus.fmap_addr, (pass % IN_CH) * N + reads);
        checkOutput("w_bank_sel_stable", bus.w_bank_sel, pass);
        reads++;
        total_reads++;
      end
      if (bus.conv_valid && !inject_now) begin
        checkOutput("res_idx", bus.res_idx, results);
        checkOutput("psum_first", bus.psum_first, (pass % IN_CH) == 0);
        checkOutput("psum_last", bus.psum_last, (pass % IN_CH) == IN_CH - 1);
        checkOutput("oc_idx", bus.oc_idx, pass / IN_CH);
        results++;
        total_res++;
        if (inject && pass == 0 && results == N) pend_inject = 1;
      end
      if (bus.done) begin
        dones++;
        checkOutput("busy_at_done", bus.busy, 0);
        checkOutput("passes_at_done", loads, PASSES);
        checkOutput("last_pass_results", results, N);
        if (mode == 0) checkOutput("done_cycle", n, PASSES * P_LEN + 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("done_one_cycle", bus.done, 0);
        checkOutput("busy_after_done", bus.busy, 0);
        checkOutput("ovf_after_done", bus.ovf_err, exp_ovf);
        finished = 1;
      end
      if (n > 4000) begin
        checkOutput("timeout_waiting_done", 0, 1);
        finished = 1;
      end
      was_rd = bus.fmap_rd;
    end
    inject_now = 1'b0;
    checkOutput("done_pulses", dones, 1);
    checkOutput("total_reads", total_reads, PASSES * N);
    checkOutput("total_results", total_res, PASSES * N);
    if (inject) checkOutput("ovf_sticky", exp_ovf, 1);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.conv_ready = 1'b0;
    bus.conv_valid = 1'b0;
    reset          = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdle("reset");

    $display("[TB] layer with ready high and stray starts");
    runLayer(0, 1'b0, 1'b1, -1, 1'b0);
    $display("[TB] layer with ready 1,0,0 pattern");
    runLayer(1, 1'b0, 1'b0, -1, 1'b0);
    $display("[TB] layer reset at rd_cnt 7 of pass 2");
    runLayer(2, 1'b0, 1'b0, 2, 1'b0);
    $display("[TB] restart with random ready and extra result in drain");
    runLayer(2, 1'b1, 1'b0, -1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkIdle("reset_clears_ovf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
